// File: rtl/pd_mavg_pkg.sv
// Shared types and helpers for the peak-detect / moving-average line sequencer.
// Supplies default pixel data and column widths when the build does not set them.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 12
`endif

package pd_mavg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SKIP   = 2'd1,
        ACTIVE = 2'd2,
        FLUSH  = 2'd3
    } seq_state_t;

    localparam int WIN_W = 5;

    // Averaging window length: 2, 4, 8 or 16 samples.
    function automatic logic [WIN_W-1:0] win_len(input logic [1:0] param);
        win_len = 5'd2 << param;
    endfunction

endpackage

// File: rtl/pd_mavg_sat_cnt.sv
// Saturating up-counter with synchronous clear; exposes the post-increment value
// (before any clear) so a caller can capture the final count in the clearing cycle.
module pd_mavg_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt_inc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_inc = cnt_q;
        if (inc && (cnt_q != {W{1'b1}}))
            cnt_inc = cnt_q + W'(1);
        cnt_d = clr ? '0 : cnt_inc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pd_mavg_seq_ctrl.sv
// Line sequencer: skips leading pixels, forwards the active window, flushes the
// moving-average pipe and reports peaks per line. PD_MAVG_SEQ_DBG_EN adds debug outputs.
module pd_mavg_seq_ctrl
    import pd_mavg_pkg::*;
#(
    parameter int FLUSH_EXTRA = 2,
    parameter int PCNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    start_act,
    input  logic                    vald_din_in,
    input  logic [`DATAWIDTH-1:0]   data_in,
    input  logic [`PIXEL_WIDTH-1:0] active_columns_start,
    input  logic [`PIXEL_WIDTH-1:0] active_columns_num,
    input  logic [1:0]              movavgwin_param,
    input  logic                    peak_valid,
    output logic                    vald_din,
    output logic [`DATAWIDTH-1:0]   data_out,
    output logic                    movavg_en,
    output logic                    pdet_en,
    output logic                    start_act_pd,
    output logic                    line_done,
    output logic [PCNT_W-1:0]       peak_cnt,
    output logic                    busy
`ifdef PD_MAVG_SEQ_DBG_EN
    ,
    output logic [15:0]             dbg_line_cnt,
    output logic                    dbg_abort
`endif
);

    localparam int DW     = `DATAWIDTH;
    localparam int PW     = `PIXEL_WIDTH;
    localparam int FCNT_W = 8;

    seq_state_t        state_q, state_d;
    logic [PW-1:0]     col_cnt_q, col_cnt_d;
    logic [FCNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic              vald_din_q, vald_din_d;
    logic [DW-1:0]     data_q, data_d;
    logic              movavg_en_q, movavg_en_d;
    logic              pdet_en_q, pdet_en_d;
    logic              start_pd_q, start_pd_d;
    logic              line_done_q, line_done_d;
    logic [PCNT_W-1:0] peak_cnt_q, peak_cnt_d;
    logic              busy_q, busy_d;

    logic              line_start, flush_end, pk_inc, pk_clr;
    logic [PW-1:0]     col_nxt;
    logic [WIN_W-1:0]  win_new;
    logic [FCNT_W-1:0] load_cur, load_new;
    logic [PCNT_W-1:0] line_pk_inc;

    assign line_start = enable && start_act;
    assign flush_end  = (state_q == FLUSH) && (flush_cnt_q == '0);
    assign pk_inc     = peak_valid && ((state_q == ACTIVE) || (state_q == FLUSH));
    assign col_nxt    = col_cnt_q + PW'(1);
    assign win_new    = win_len(movavgwin_param);
    // Flush counter is a down-counter; loading W+EXTRA-1 yields W+EXTRA cycles.
    assign load_cur   = FCNT_W'(win_q) + FCNT_W'(FLUSH_EXTRA) - FCNT_W'(1);
    assign load_new   = FCNT_W'(win_new) + FCNT_W'(FLUSH_EXTRA) - FCNT_W'(1);

    pd_mavg_sat_cnt #(.W(PCNT_W)) u_line_pk (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (pk_clr),
        .inc     (pk_inc),
        .cnt_inc (line_pk_inc)
    );

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        flush_cnt_d = flush_cnt_q;
        win_d       = win_q;
        vald_din_d  = 1'b0;
        data_d      = data_q;
        start_pd_d  = 1'b0;
        line_done_d = 1'b0;
        peak_cnt_d  = peak_cnt_q;
        pk_clr      = 1'b0;

        case (state_q)
            SKIP: begin
                if (vald_din_in) begin
                    if (col_nxt == active_columns_start) begin
                        col_cnt_d = '0;
                        if (active_columns_num == '0) begin
                            state_d     = FLUSH;
                            flush_cnt_d = load_cur;
                        end else begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        col_cnt_d = col_nxt;
                    end
                end
            end
            ACTIVE: begin
                if (vald_din_in) begin
                    vald_din_d = 1'b1;
                    data_d     = data_in;
                    start_pd_d = (col_cnt_q == '0);
                    if (col_nxt == active_columns_num) begin
                        state_d     = FLUSH;
                        flush_cnt_d = load_cur;
                        col_cnt_d   = '0;
                    end else begin
                        col_cnt_d = col_nxt;
                    end
                end
            end
            FLUSH: begin
                if (flush_end) begin
                    state_d     = IDLE;
                    line_done_d = 1'b1;
                    peak_cnt_d  = line_pk_inc;
                end else begin
                    flush_cnt_d = flush_cnt_q - FCNT_W'(1);
                end
            end
            default: ;
        endcase

        // A line start wins over in-flight work; a completing line still reports.
        if (line_start) begin
            vald_din_d = 1'b0;
            start_pd_d = 1'b0;
            data_d     = data_q;
            pk_clr     = 1'b1;
            col_cnt_d  = '0;
            win_d      = win_new;
            if (active_columns_start != '0) begin
                state_d = SKIP;
            end else if (active_columns_num != '0) begin
                state_d = ACTIVE;
            end else begin
                state_d     = FLUSH;
                flush_cnt_d = load_new;
            end
        end

        if (!enable) begin
            state_d     = IDLE;
            col_cnt_d   = '0;
            vald_din_d  = 1'b0;
            start_pd_d  = 1'b0;
            data_d      = data_q;
            line_done_d = 1'b0;
            peak_cnt_d  = peak_cnt_q;
        end

        busy_d      = (state_d != IDLE);
        movavg_en_d = (state_d == ACTIVE) || (state_d == FLUSH);
        pdet_en_d   = (state_d == ACTIVE) || (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            col_cnt_q   <= '0;
            flush_cnt_q <= '0;
            win_q       <= '0;
            vald_din_q  <= 1'b0;
            data_q      <= '0;
            movavg_en_q <= 1'b0;
            pdet_en_q   <= 1'b0;
            start_pd_q  <= 1'b0;
            line_done_q <= 1'b0;
            peak_cnt_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            win_q       <= win_d;
            vald_din_q  <= vald_din_d;
            data_q      <= data_d;
            movavg_en_q <= movavg_en_d;
            pdet_en_q   <= pdet_en_d;
            start_pd_q  <= start_pd_d;
            line_done_q <= line_done_d;
            peak_cnt_q  <= peak_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign vald_din     = vald_din_q;
    assign data_out     = data_q;
    assign movavg_en    = movavg_en_q;
    assign pdet_en      = pdet_en_q;
    assign start_act_pd = start_pd_q;
    assign line_done    = line_done_q;
    assign peak_cnt     = peak_cnt_q;
    assign busy         = busy_q;

`ifdef PD_MAVG_SEQ_DBG_EN
    logic        abort;
    logic [15:0] dbg_line_cnt_q, dbg_line_cnt_d;
    logic        dbg_abort_q, dbg_abort_d;

    assign abort = line_start && (state_q != IDLE) && !flush_end;

    always_comb begin
        dbg_line_cnt_d = dbg_line_cnt_q + (line_done_d ? 16'd1 : 16'd0);
        dbg_abort_d    = dbg_abort_q | abort;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbg_line_cnt_q <= '0;
            dbg_abort_q    <= 1'b0;
        end else begin
            dbg_line_cnt_q <= dbg_line_cnt_d;
            dbg_abort_q    <= dbg_abort_d;
        end
    end

    assign dbg_line_cnt = dbg_line_cnt_q;
    assign dbg_abort    = dbg_abort_q;
`endif

endmodule

// File: tb/tb_pd_mavg_seq_ctrl.sv
// Scoreboard bench for pd_mavg_seq_ctrl: forwarded pixels and line completions are
// predicted as stimulus is driven and compared as the DUT produces them.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 12
`endif

module tb_pd_mavg_seq_ctrl;

    localparam int DW  = `DATAWIDTH;
    localparam int PW  = `PIXEL_WIDTH;
    localparam int FX  = 2;
    localparam int PCW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          start_act = 1'b0;
    logic          vald_din_in = 1'b0;
    logic          peak_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [PW-1:0] act_start = '0;
    logic [PW-1:0] act_num = '0;
    logic [1:0]    win_param = '0;

    logic           vald_din, movavg_en, pdet_en, start_act_pd, line_done, busy;
    logic [DW-1:0]  data_out;
    logic [PCW-1:0] peak_cnt;
`ifdef PD_MAVG_SEQ_DBG_EN
    logic [15:0]    dbg_line_cnt;
    logic           dbg_abort;
`endif

    pd_mavg_seq_ctrl #(.FLUSH_EXTRA(FX), .PCNT_W(PCW)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .enable               (enable),
        .start_act            (start_act),
        .vald_din_in          (vald_din_in),
        .data_in              (data_in),
        .active_columns_start (act_start),
        .active_columns_num   (act_num),
        .movavgwin_param      (win_param),
        .peak_valid           (peak_valid),
        .vald_din             (vald_din),
        .data_out             (data_out),
        .movavg_en            (movavg_en),
        .pdet_en              (pdet_en),
        .start_act_pd         (start_act_pd),
        .line_done            (line_done),
        .peak_cnt             (peak_cnt),
        .busy                 (busy)
`ifdef PD_MAVG_SEQ_DBG_EN
        ,
        .dbg_line_cnt         (dbg_line_cnt),
        .dbg_abort            (dbg_abort)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        bit            first;
        int            cyc;
    } pix_t;

    typedef struct {
        int cyc;
        int peak;
    } line_t;

    pix_t  pix_q[$];
    line_t line_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    busy_chk_cyc = -10;
    int    exp_lines = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vald_din"}, 32'(vald_din), 0);
        chk({tag, "_data_out"}, 32'(data_out), 0);
        chk({tag, "_movavg_en"}, 32'(movavg_en), 0);
        chk({tag, "_pdet_en"}, 32'(pdet_en), 0);
        chk({tag, "_start_act_pd"}, 32'(start_act_pd), 0);
        chk({tag, "_line_done"}, 32'(line_done), 0);
        chk({tag, "_peak_cnt"}, 32'(peak_cnt), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (vald_din) begin
                if (pix_q.size() == 0) begin
                    chk("vald_din_unexpected", 1, 0);
                end else begin
                    pix_t p;
                    p = pix_q.pop_front();
                    chk("vald_din_cycle", cyc, p.cyc);
                    chk("data_out", 32'(data_out), 32'(p.data));
                    chk("start_act_pd", 32'(start_act_pd), 32'(p.first));
                    chk("movavg_en_active", 32'(movavg_en), 1);
                    chk("pdet_en_active", 32'(pdet_en), 1);
                end
            end else if (start_act_pd) begin
                chk("start_act_pd_no_valid", 1, 0);
            end
            if (line_q.size() != 0 && cyc == line_q[0].cyc - 1)
                chk("flush_last_movavg_en", 32'(movavg_en), 1);
            if (line_done) begin
                if (line_q.size() == 0) begin
                    chk("line_done_unexpected", 1, 0);
                end else begin
                    line_t l;
                    l = line_q.pop_front();
                    chk("line_done_cycle", cyc, l.cyc);
                    chk("peak_cnt", 32'(peak_cnt), l.peak);
                    chk("movavg_en_after_done", 32'(movavg_en), 0);
                    chk("pdet_en_after_done", 32'(pdet_en), 0);
                end
            end else if (line_q.size() != 0 && cyc > line_q[0].cyc) begin
                chk("line_done_missing", cyc, line_q[0].cyc);
                void'(line_q.pop_front());
            end
            if (cyc == busy_chk_cyc || cyc == busy_chk_cyc + 1)
                chk("busy_restart", 32'(busy), 1);
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Drives start_act, then np contiguous pixels; predicts output pixels and line end.
    task automatic run_line(input int st, input int nm, input int pr, input int np,
                            input int npk, input bit exp_done, output int done_cyc);
        int s;
        int w;
        int pk;
        @(negedge clk);
        act_start = PW'(st);
        act_num   = PW'(nm);
        win_param = 2'(pr);
        start_act = 1'b1;
        s  = cyc + 1;
        w  = 2 << pr;
        pk = 0;
        @(negedge clk);
        start_act = 1'b0;
        for (int i = 1; i <= np; i++) begin
            vald_din_in = 1'b1;
            data_in     = DW'($urandom);
            peak_valid  = 1'b0;
            if (i > st && i <= st + nm) begin
                pix_t p;
                p.data  = data_in;
                p.first = (i == st + 1);
                p.cyc   = cyc + 1;
                pix_q.push_back(p);
                if (pk < npk) begin
                    peak_valid = 1'b1;
                    pk++;
                end
            end
            @(negedge clk);
        end
        vald_din_in = 1'b0;
        peak_valid  = 1'b0;
        done_cyc = s + st + nm + w + FX;
        if (exp_done) begin
            line_t l;
            l.cyc  = done_cyc;
            l.peak = (pk > 255) ? 255 : pk;
            line_q.push_back(l);
            exp_lines++;
        end
    endtask

    initial begin
        int d;
        int d2;
        int budget;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        enable  = 1'b1;

        // Window 4: pixels 4..8 forwarded, line_done 6 cycles after the last one.
        run_line(3, 5, 1, 10, 2, 1, d);
        wait_cyc(d + 1);
        chk("idle_after_line", 32'(busy), 0);

        // Dropping enable mid-line: IDLE next clock, peak count held.
        run_line(1, 4, 0, 3, 1, 0, d);
        enable = 1'b0;
        @(negedge clk);
        chk("enable_low_busy", 32'(busy), 0);
        chk("enable_low_movavg_en", 32'(movavg_en), 0);
        chk("enable_low_peak_hold", 32'(peak_cnt), 2);
        enable = 1'b1;
        repeat (12) @(negedge clk);

        // Empty line: flush only.
        run_line(0, 0, 0, 0, 0, 1, d);
        wait_cyc(d + 1);

        // Peak counter saturation.
        run_line(0, 300, 3, 300, 300, 1, d);
        wait_cyc(d + 1);

        run_line(2, 4, 2, 6, 3, 1, d);
        wait_cyc(d + 1);

        // Abort after 3 of 5 active pixels, then a full line.
        run_line(2, 5, 0, 5, 3, 0, d);
        run_line(2, 5, 0, 7, 2, 1, d);
        wait_cyc(d + 1);
`ifdef PD_MAVG_SEQ_DBG_EN
        chk("dbg_abort_set", 32'(dbg_abort), 1);
        chk("dbg_line_cnt", 32'(dbg_line_cnt), exp_lines);
`endif

        // start_act coinciding with the last FLUSH cycle.
        run_line(1, 2, 0, 3, 1, 1, d);
        wait_cyc(d - 2);
        busy_chk_cyc = d;
        run_line(2, 3, 1, 5, 2, 1, d2);
        wait_cyc(d2 + 1);
        chk("idle_after_restart_line", 32'(busy), 0);

        // Reset pulse mid-FLUSH discards the line.
        run_line(1, 2, 0, 3, 2, 0, d);
        wait_cyc(d - 3);
        reset_n = 1'b0;
        #1;
        chk_all_zero("mid_flush_reset");
        @(negedge clk);
        reset_n = 1'b1;
        exp_lines = 0;
        wait_cyc(d + 4);
        chk("idle_after_reset", 32'(busy), 0);
`ifdef PD_MAVG_SEQ_DBG_EN
        chk("dbg_abort_cleared", 32'(dbg_abort), 0);
`endif

        run_line(0, 3, 0, 3, 1, 1, d);
        wait_cyc(d + 1);
`ifdef PD_MAVG_SEQ_DBG_EN
        chk("dbg_line_cnt_after_reset", 32'(dbg_line_cnt), exp_lines);
`endif

        budget = 0;
        while ((pix_q.size() != 0 || line_q.size() != 0) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_pixels", pix_q.size(), 0);
        chk("drain_lines", line_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pd_mavg_seq_ctrl.md
PD_MAVG_SEQ_CTRL -- requirements
Module: pd_mavg_seq_ctrl

Interface
REQ-001 Parameters SHALL be: FLUSH_EXTRA, 2, extra flush cycles covering the moving-average pipeline latency; PCNT_W, 8, peak counter width.
REQ-002 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-003 Port reset_n, input, 1, asynchronous active-low reset.
REQ-004 Port enable, input, 1, global sequencer enable; a low level forces IDLE.
REQ-005 Port start_act, input, 1, line-start pulse.
REQ-006 Port vald_din_in, input, 1, raw pixel valid.
REQ-007 Port data_in, input, `DATAWIDTH, raw pixel data.
REQ-008 Port active_columns_start, input, `PIXEL_WIDTH, number of leading pixels skipped.
REQ-009 Port active_columns_num, input, `PIXEL_WIDTH, number of active pixels forwarded.
REQ-010 Port movavgwin_param, input, 2, averaging window W = 2^(param+1), giving 2, 4, 8 or 16.
REQ-011 Port peak_valid, input, 1, peak-detector strobe.
REQ-012 Port vald_din, output, 1, gated valid to the moving-average stage.
REQ-013 Port data_out, output, `DATAWIDTH, registered pixel data.
REQ-014 Port movavg_en, output, 1, moving-average enable.
REQ-015 Port pdet_en, output, 1, peak-detect enable.
REQ-016 Port start_act_pd, output, 1, line-start pulse to the peak detector.
REQ-017 Port line_done, output, 1, one-cycle pulse when a line completes.
REQ-018 Port peak_cnt, output, PCNT_W, number of peaks in the last completed line.
REQ-019 Port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, SKIP, ACTIVE and FLUSH.
REQ-021 IDLE SHALL move to SKIP on start_act&&enable; on that entry col_cnt, line_pk clear and W is latched from movavgwin_param.
REQ-022 SKIP SHALL count vald_din_in; after active_columns_start valid pixels it moves to ACTIVE (immediately if 0).
REQ-023 In ACTIVE, each vald_din_in SHALL produce vald_din=1 and data_out=data_in one cycle later (latency 1).
REQ-024 After active_columns_num valid pixels, ACTIVE SHALL move to FLUSH; if active_columns_num=0, SKIP goes directly to FLUSH.
REQ-025 start_act_pd SHALL pulse in the same cycle as the first vald_din of a line, and never on an empty line.
REQ-026 FLUSH SHALL last exactly W+FLUSH_EXTRA cycles, with vald_din=0.
REQ-027 At FLUSH end, FLUSH SHALL move to IDLE, pulse line_done and load peak_cnt with line_pk, all in the same cycle.
REQ-028 movavg_en SHALL be 1 in ACTIVE and FLUSH; pdet_en SHALL be 1 in ACTIVE and FLUSH.
REQ-029 line_pk SHALL increment on peak_valid in ACTIVE/FLUSH and saturate at all-ones; peak_valid in other states SHALL be ignored.
REQ-030 A start_act in SKIP/ACTIVE/FLUSH SHALL abort the line with no line_done and peak_cnt unchanged, then restart in SKIP as in REQ-021.
REQ-031 A start_act in the same cycle as the FLUSH-end cycle SHALL complete the old line (line_done, peak_cnt) and enter SKIP.
REQ-032 enable=0 SHALL force IDLE on the next clock, with no line_done and peak_cnt held.

Reset
REQ-033 While reset_n=0, the FSM SHALL be IDLE, all counters 0, and every output 0, including data_out and peak_cnt.
REQ-034 Reset asserted mid-line SHALL discard the line; the first start_act after release starts a fresh line.

Configuration
REQ-035 With PD_MAVG_SEQ_DBG_EN defined, the block SHALL add the outputs dbg_line_cnt[15:0] (completed lines, wrapping) and dbg_abort (sticky, set on any REQ-030 abort, cleared only by reset).
REQ-036 Without PD_MAVG_SEQ_DBG_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-037 A shared package pd_mavg_pkg SHALL hold the state enum seq_state_t and the function win_len(param) returning W; widths SHALL come from `DATAWIDTH and `PIXEL_WIDTH.
REQ-038 The block SHALL have one sub-module, pd_mavg_sat_cnt (parameterised saturating counter), used for line_pk.

Verification
REQ-039 start=3, num=5, param=1, 10 contiguous pixels -> vald_din high for pixels 4..8 at latency 1; start_act_pd pulses with pixel 4; line_done 4+2 cycles after last vald_din.
REQ-040 start=0, num=0, param=0 -> no vald_din, no start_act_pd; line_done 4 cycles after start_act; peak_cnt=0.
REQ-041 300 peak_valid pulses in ACTIVE with PCNT_W=8 -> peak_cnt=255 at line_done.
REQ-042 start_act again mid-ACTIVE after 3 of 5 pixels -> no line_done; new line counts skip from 0; dbg_abort=1 when DBG_EN.
REQ-043 start_act in the FLUSH-end cycle -> line_done=1, peak_cnt updated, state SKIP next cycle, busy stays 1.
REQ-044 reset_n low for 1 cycle mid-FLUSH -> all outputs 0 immediately, IDLE; no line_done on release.
